// File: rtl/regfile_pkg.sv
// Shared constants, address type and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_D = 32;
    localparam int NREG_D = 32;
    localparam int AW_D   = $clog2(NREG_D);

    typedef logic [AW_D-1:0] reg_addr_t;

    // Callers zero-extend their address so any AW works with one helper.
    function automatic logic is_zero(input logic [31:0] addr);
        return addr == 32'd0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for outstanding loads plus per-port RAW and issue WAW hazard detection.
// RF_BYPASS_EN: a returning load hides the busy flag from same-cycle readers of its register.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_D,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic              iss_ld,
    input  logic [AW-1:0]     iss_rd,
    output logic [NRD-1:0]    rd_busy,
    output logic              stall,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign set_vec[gi] = iss_ld && (iss_rd == AW'(gi))
                                 && !((ZERO_REG != 0) && is_zero(32'(gi)));
            assign clr_vec[gi] = ld_we && (ld_addr == AW'(gi));
        end

        for (gi = 0; gi < NRD; gi++) begin : g_haz
            logic [AW-1:0] addr;
            logic          hit;
            assign addr = rd_addr[gi*AW +: AW];
`ifdef RF_BYPASS_EN
            assign hit = rd_en[gi] && busy_reg[addr] && !(ld_we && (ld_addr == addr));
`else
            assign hit = rd_en[gi] && busy_reg[addr];
`endif
            assign rd_busy[gi] = reset && hit;
        end
    endgenerate

    // A new load issued on the same edge its predecessor returns keeps the register busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= (busy_reg & ~clr_vec) | set_vec;
        end
    end

    assign busy_vec = busy_reg;
    assign stall    = (|rd_busy) || (reset && iss_ld && busy_reg[iss_rd]);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with ALU and load-return write ports and a load scoreboard.
// RF_BYPASS_EN: same-cycle write data is forwarded to matching reads (load over ALU).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREG     = NREG_D,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                ld_we,
    input  logic [AW-1:0]       ld_addr,
    input  logic [XLEN-1:0]     ld_data,
    input  logic                iss_ld,
    input  logic [AW-1:0]       iss_rd,
    output logic                stall,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] ld_hit;
    logic [NREG-1:0] wb_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_we
            logic wr_ok;
            assign wr_ok       = !((ZERO_REG != 0) && is_zero(32'(gi)));
            assign ld_hit[gi]  = wr_ok && ld_we && (ld_addr == AW'(gi));
            assign wb_hit[gi]  = wr_ok && wb_we && (wb_addr == AW'(gi));
        end
    endgenerate

    // The load return takes precedence when both ports target one register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (ld_hit[r]) begin
                    regs[r] <= ld_data;
                end else if (wb_hit[r]) begin
                    regs[r] <= wb_data;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] val;
            logic            force_zero;
            assign addr = rd_addr[gi*AW +: AW];
`ifdef RF_BYPASS_EN
            assign val = (ld_we && (ld_addr == addr)) ? ld_data :
                         (wb_we && (wb_addr == addr)) ? wb_data : regs[addr];
`else
            assign val = regs[addr];
`endif
            assign force_zero = !reset || !rd_en[gi]
                                || ((ZERO_REG != 0) && is_zero(32'(addr)));
            assign rd_data[gi*XLEN +: XLEN] = force_zero ? '0 : val;
        end
    endgenerate

    rf_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .iss_ld   (iss_ld),
        .iss_rd   (iss_rd),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wb_we;
    reg_addr_t   wb_addr;
    logic [31:0] wb_data;
    logic        ld_we;
    reg_addr_t   ld_addr;
    logic [31:0] ld_data;
    logic        iss_ld;
    reg_addr_t   iss_rd;
    logic        stall;
    logic [31:0] busy_vec;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .iss_ld   (iss_ld),
        .iss_rd   (iss_rd),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we  = 1'b0;
        ld_we  = 1'b0;
        iss_ld = 1'b0;
        rd_en  = 2'b00;
    endtask

    task automatic rd(input int p, input reg_addr_t a);
        rd_en[p]          = 1'b1;
        rd_addr[p*5 +: 5] = a;
    endtask

    initial begin
        reset   = 1'b0;
        rd_addr = '0;
        wb_addr = '0;
        wb_data = '0;
        ld_addr = '0;
        ld_data = '0;
        iss_rd  = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("busy_vec in reset", busy_vec, 32'd0);
        chk("stall in reset", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Cleared file reads zero everywhere on both ports.
        for (int a = 0; a < 32; a++) begin
            rd(0, reg_addr_t'(a));
            rd(1, reg_addr_t'(a));
            #1;
            chk($sformatf("x%0d p0 after reset", a), rd_data[31:0], 32'd0);
            chk($sformatf("x%0d p1 after reset", a), rd_data[63:32], 32'd0);
        end
        chk("busy_vec after reset", busy_vec, 32'd0);
        chk("stall after reset", {31'd0, stall}, 32'd0);
        idle();

        // ALU writeback then read.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        rd(0, 5'd5);
        #1;
`ifdef RF_BYPASS_EN
        chk("x5 same-cycle bypass", rd_data[31:0], 32'hDEADBEEF);
`else
        chk("x5 same-cycle stored", rd_data[31:0], 32'd0);
`endif
        step();
        wb_we = 1'b0;
        #1;
        chk("x5 after wb", rd_data[31:0], 32'hDEADBEEF);
        rd_en = 2'b00;
        #1;
        chk("x5 rd_en off", rd_data[31:0], 32'd0);

        // Load beats ALU on a collision; x0 ignores writes.
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
        ld_we = 1'b1; ld_addr = 5'd7; ld_data = 32'h22;
        step();
        idle();
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
        step();
        idle();
        rd(0, 5'd7);
        rd(1, 5'd0);
        #1;
        chk("x7 ld priority", rd_data[31:0], 32'h22);
        chk("x0 write ignored", rd_data[63:32], 32'd0);
        idle();

        // Outstanding load on x9: RAW hazard until return.
        iss_ld = 1'b1; iss_rd = 5'd9;
        step();
        idle();
        rd(1, 5'd9);
        #1;
        chk("x9 rd_busy", {30'd0, rd_busy}, 32'd2);
        chk("x9 stall", {31'd0, stall}, 32'd1);
        chk("x9 busy_vec", busy_vec, 32'h0000_0200);
        ld_we = 1'b1; ld_addr = 5'd9; ld_data = 32'h1234;
        #1;
`ifdef RF_BYPASS_EN
        chk("x9 rd_busy on return", {30'd0, rd_busy}, 32'd0);
`else
        chk("x9 rd_busy on return", {30'd0, rd_busy}, 32'd2);
`endif
        step();
        ld_we = 1'b0;
        #1;
        chk("x9 busy cleared", busy_vec, 32'd0);
        chk("x9 load data", rd_data[63:32], 32'h1234);
        chk("x9 no stall", {31'd0, stall}, 32'd0);
        idle();

        // Set wins over clear on the same edge; re-issue while busy is a WAW stall.
        iss_ld = 1'b1; iss_rd = 5'd3;
        step();
        ld_we = 1'b1; ld_addr = 5'd3; ld_data = 32'h55;
        #1;
        chk("x3 WAW stall", {31'd0, stall}, 32'd1);
        step();
        idle();
        rd(0, 5'd3);
        #1;
        chk("x3 still busy", busy_vec, 32'h0000_0008);
        chk("x3 data returned", rd_data[31:0], 32'h55);
        iss_ld = 1'b1; iss_rd = 5'd0;
        rd_en = 2'b00;
        #1;
        chk("x0 issue no stall", {31'd0, stall}, 32'd0);
        step();
        idle();
        chk("x0 never busy", busy_vec, 32'h0000_0008);
        ld_we = 1'b1; ld_addr = 5'd3; ld_data = 32'h66;
        step();
        idle();

        // Asynchronous reset mid-operation.
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hA5;
        iss_ld = 1'b1; iss_rd = 5'd4;
        step();
        idle();
        rd(0, 5'd4);
        rd(1, 5'd4);
        #1;
        chk("x4 before reset", rd_data[31:0], 32'hA5);
        chk("x4 busy before reset", busy_vec, 32'h0000_0010);
        #2;
        reset = 1'b0;
        #1;
        chk("x4 async reset data", rd_data[31:0], 32'd0);
        chk("async reset busy_vec", busy_vec, 32'd0);
        chk("async reset rd_busy", {30'd0, rd_busy}, 32'd0);
        chk("async reset stall", {31'd0, stall}, 32'd0);
        #2;
        reset = 1'b1;
        step();
        chk("x4 after release", rd_data[63:32], 32'd0);
        chk("busy after release", busy_vec, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
